// File: rtl/output_deskew_register.sv
`default_nettype none

`ifndef DATASIZE
`define DATASIZE 16
`endif

`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif

// ============================================================================
// Module      : output_deskew_register
// Description : Per-column result collector for the bottom edge of the
//               systolic array. Discards the column's leading skew strobes,
//               captures ARRAYWIDTH results in order, then replays them
//               aligned to the result writer over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module output_deskew_register #(
  parameter int DATASIZE   = `DATASIZE,
  parameter int ARRAYWIDTH = `ARRAYWIDTH,
  parameter int DELAY_NUM  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_en,
  input  logic [DATASIZE-1:0] in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATASIZE-1:0] out,
  output logic                out_last,
  output logic                busy,
  output logic                overrun
);

  // Pointer width is clog2 of the buffer depth, never narrower than 1 bit.
  // The skip counter shares this width since DELAY_NUM < ARRAYWIDTH.
  localparam int PTR_W = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1;

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(ARRAYWIDTH - 1);
  localparam logic [PTR_W-1:0] SKIP_INIT = PTR_W'(DELAY_NUM);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                state_q,    state_d;
  logic [PTR_W-1:0]      skip_cnt_q, skip_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic                  overrun_q,  overrun_d;
  logic [DATASIZE-1:0]   mem_q [ARRAYWIDTH];

  logic                  capture_fire;
  logic                  drain_fire;

  // A strobe is stored only while capturing; a beat retires only while draining.
  always_comb begin
    capture_fire = (state_q == S_CAPTURE) && in_en;
    drain_fire   = (state_q == S_DRAIN) && out_ready;
  end

  // Next-state logic for the collection sequence and its pointers.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        // Strobes in IDLE are stray drain traffic for another pass; ignore them.
        if (start) begin
          wr_ptr_d = '0;
          if (DELAY_NUM > 0) begin
            state_d    = S_SKIP;
            skip_cnt_d = SKIP_INIT;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end

      S_SKIP: begin
        // The strobe that empties the counter is itself still a skew slot.
        if (in_en) begin
          skip_cnt_d = skip_cnt_q - PTR_ONE;
          if (skip_cnt_q == PTR_ONE) begin
            state_d = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        if (in_en) begin
          if (wr_ptr_q == LAST_IDX) begin
            state_d  = S_DRAIN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end
      end

      S_DRAIN: begin
        // Late strobes cannot be stored without corrupting the replay; flag them.
        if (in_en) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          if (rd_ptr_q == LAST_IDX) begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any partial collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
    end
  end

  // Result buffer: written in order during capture, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARRAYWIDTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture_fire) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  // Outputs decode straight from registers so the writer sees no input-to-output path.
  always_comb begin
    out_valid = (state_q == S_DRAIN);
    out       = out_valid ? mem_q[rd_ptr_q] : '0;
    out_last  = out_valid && (rd_ptr_q == LAST_IDX);
    busy      = (state_q != S_IDLE);
    overrun   = overrun_q;
  end

  // drain_fire documents the retire condition used by the DRAIN branch above.
  logic unused_drain_fire;
  always_comb begin
    unused_drain_fire = drain_fire;
  end

endmodule

`default_nettype wire

// File: tb/tb_output_deskew_register.sv
`default_nettype none

// ============================================================================
// Module      : tb_output_deskew_register
// Description : Self-checking bench for output_deskew_register with three
//               column instances (DELAY_NUM = 0, 1, 2), ARRAYWIDTH=4,
//               DATASIZE=16. Expected beats are queued as stimulus is driven
//               and compared as the DUT replays them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_deskew_register;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic [2:0]    start;
  logic          in_en;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic [2:0]    vld, lst, bsy, ovr;
  logic [DW-1:0] dout [3];

  int checks;
  int failures;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];

  int            sel;
  logic          s_valid, s_last, s_busy, s_ovr;
  logic [DW-1:0] s_out;

  output_deskew_register #(.DATASIZE(DW), .ARRAYWIDTH(AW), .DELAY_NUM(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_en(in_en), .in(in_data),
    .out_valid(vld[0]), .out_ready(out_ready), .out(dout[0]), .out_last(lst[0]),
    .busy(bsy[0]), .overrun(ovr[0]));

  output_deskew_register #(.DATASIZE(DW), .ARRAYWIDTH(AW), .DELAY_NUM(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_en(in_en), .in(in_data),
    .out_valid(vld[1]), .out_ready(out_ready), .out(dout[1]), .out_last(lst[1]),
    .busy(bsy[1]), .overrun(ovr[1]));

  output_deskew_register #(.DATASIZE(DW), .ARRAYWIDTH(AW), .DELAY_NUM(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start[2]), .in_en(in_en), .in(in_data),
    .out_valid(vld[2]), .out_ready(out_ready), .out(dout[2]), .out_last(lst[2]),
    .busy(bsy[2]), .overrun(ovr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    s_valid = vld[sel];
    s_last  = lst[sel];
    s_busy  = bsy[sel];
    s_ovr   = ovr[sel];
    s_out   = dout[sel];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int idx);
    start      = '0;
    start[idx] = 1'b1;
    tick();
    start      = '0;
  endtask

  // Drive one drain-phase cycle; push to the scoreboard if it should be kept.
  task automatic drive(input logic en, input logic [DW-1:0] d, input bit keep);
    in_en   = en;
    in_data = d;
    if (keep) exp_q.push_back(d);
    tick();
    in_en   = 1'b0;
    in_data = '0;
  endtask

  // Record accepted beats; out_ready follows a repeating pattern. Counts
  // cycles used and cycles where a stalled value changed.
  task automatic collect(input int nbeats, input logic [15:0] pat, input int plen,
                         output int cycles, output int holdviol);
    int            beats = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_out   = '0;
    cycles   = 0;
    holdviol = 0;
    while (beats < nbeats && cycles < 100) begin
      out_ready = pat[cycles % plen];
      @(negedge clk);
      if (prev_stall && (!s_valid || s_out !== prev_out)) holdviol++;
      if (s_valid && out_ready) begin
        obs_data.push_back(s_out);
        obs_last.push_back(s_last);
        beats++;
      end
      prev_stall = s_valid && !out_ready;
      prev_out   = s_out;
      @(posedge clk);
      #1;
      cycles++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      checks++;
      if ({s_valid, s_last, s_busy, s_ovr} !== 4'b0 || s_out !== '0) begin
        failures++;
        $display("FAIL reset_state dut%0d: valid=%b last=%b busy=%b ovr=%b out=%h, required all 0",
                 i, s_valid, s_last, s_busy, s_ovr, s_out);
      end
    end
  endtask

  task automatic test_delay0();
    int cyc, hv;
    sel = 0;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    pulse_start(0);
    drive(1, 16'h0011, 1); drive(1, 16'h0022, 1); drive(1, 16'h0033, 1); drive(1, 16'h0044, 1);
    checks++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL d0_first_valid: out_valid=%b, required 1", s_valid);
    end
    collect(4, 16'hFFFF, 1, cyc, hv);
    checks++;
    if (cyc != 4) begin
      failures++;
      $display("FAIL d0_consecutive: cycles=%0d, required 4", cyc);
    end
    for (int i = 0; i < AW; i++) begin
      checks++;
      if (obs_data.size() == 0) begin
        failures++;
        $display("FAIL d0_beat%0d: no beat, required %h", i, exp_q[0]);
        exp_q.delete();
        break;
      end else begin
        logic [DW-1:0] e = exp_q.pop_front();
        logic [DW-1:0] o = obs_data.pop_front();
        logic          l = obs_last.pop_front();
        if (o !== e || l !== (i == AW - 1)) begin
          failures++;
          $display("FAIL d0_beat%0d: out=%h last=%b, required out=%h last=%b", i, o, l, e, (i == AW - 1));
        end
      end
    end
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_out !== '0) begin
      failures++;
      $display("FAIL d0_done: busy=%b valid=%b out=%h, required 0 0 0000", s_busy, s_valid, s_out);
    end
  endtask

  task automatic test_delay2();
    int cyc, hv;
    sel = 2;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    pulse_start(2);
    drive(1, 16'h00AA, 0); drive(1, 16'h00BB, 0);
    drive(1, 16'h0001, 1); drive(1, 16'h0002, 1); drive(1, 16'h0003, 1); drive(1, 16'h0004, 1);
    collect(4, 16'hFFFF, 1, cyc, hv);
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_data.size() == 0) begin
        failures++;
        $display("FAIL d2_beat: no beat, required %h", e);
      end else begin
        logic [DW-1:0] o = obs_data.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL d2_beat: out=%h, required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, hv;
    sel = 1;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    pulse_start(1);
    drive(1, 16'hDEAD, 0);
    for (int i = 1; i <= AW; i++) drive(1, DW'(16'h1000 + i), 1);
    collect(4, 16'b10010, 5, cyc, hv);
    checks++;
    if (hv != 0) begin
      failures++;
      $display("FAIL bp_hold: stalled value changed %0d times, required 0", hv);
    end
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_data.size() == 0) begin
        failures++;
        $display("FAIL bp_beat: no beat, required %h", e);
      end else begin
        logic [DW-1:0] o = obs_data.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL bp_beat: out=%h, required %h", o, e);
        end
      end
    end
    checks++;
    if (s_valid !== 1'b0 || s_out !== '0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: valid=%b out=%h busy=%b, required 0 0000 0", s_valid, s_out, s_busy);
    end
  endtask

  task automatic test_gaps();
    int cyc, hv;
    logic [6:0] pat = 7'b1100101; // bit i = in_en at step i: 1,0,1,0,0,1,1
    sel = 1;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    pulse_start(1);
    for (int i = 0; i < 7; i++) drive(pat[i], DW'(16'h4000 + i), pat[i] && i != 0);
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_pending: valid=%b busy=%b, required 0 1", s_valid, s_busy);
    end
    drive(1, 16'h4007, 1);
    collect(4, 16'hFFFF, 1, cyc, hv);
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_data.size() == 0) begin
        failures++;
        $display("FAIL gap_beat: no beat, required %h", e);
      end else begin
        logic [DW-1:0] o = obs_data.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL gap_beat: out=%h, required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_misuse();
    int cyc, hv;
    sel = 0;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    pulse_start(0);
    drive(1, 16'h0A01, 1); drive(1, 16'h0A02, 1);
    start[0] = 1'b1;
    drive(1, 16'h0A03, 1);
    start[0] = 1'b0;
    drive(1, 16'h0A04, 1);
    checks++;
    if (s_valid !== 1'b1 || s_out !== 16'h0A01) begin
      failures++;
      $display("FAIL misuse_start: valid=%b out=%h, required 1 0a01", s_valid, s_out);
    end
    out_ready = 1'b0;
    drive(1, 16'hBEEF, 0);
    checks++;
    if (s_ovr !== 1'b1 || s_out !== 16'h0A01) begin
      failures++;
      $display("FAIL misuse_overrun: overrun=%b out=%h, required 1 0a01", s_ovr, s_out);
    end
    collect(4, 16'hFFFF, 1, cyc, hv);
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_data.size() == 0) begin
        failures++;
        $display("FAIL misuse_beat: no beat, required %h", e);
      end else begin
        logic [DW-1:0] o = obs_data.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL misuse_beat: out=%h, required %h", o, e);
        end
      end
    end
    checks++;
    if (s_ovr !== 1'b1) begin
      failures++;
      $display("FAIL misuse_sticky: overrun=%b, required 1", s_ovr);
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc, hv;
    sel = 0;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    pulse_start(0);
    for (int i = 0; i < AW; i++) drive(1, DW'(16'h7700 + i), 0);
    collect(2, 16'hFFFF, 1, cyc, hv);
    obs_data.delete(); obs_last.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (s_valid !== 1'b0 || s_out !== '0 || s_busy !== 1'b0 || s_ovr !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_drain: valid=%b out=%h busy=%b ovr=%b, required 0 0000 0 0",
               s_valid, s_out, s_busy, s_ovr);
    end
    pulse_start(0);
    for (int i = 0; i < AW; i++) drive(1, DW'(16'h5500 + i), 1);
    collect(4, 16'hFFFF, 1, cyc, hv);
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_data.size() == 0) begin
        failures++;
        $display("FAIL rst_fresh_beat: no beat, required %h", e);
      end else begin
        logic [DW-1:0] o = obs_data.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL rst_fresh_beat: out=%h, required %h", o, e);
        end
      end
    end
    checks++;
    if (obs_data.size() != 0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_fresh_extra: extra beats=%0d valid=%b, required 0 0", obs_data.size(), s_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 0;
    rst       = 1'b1;
    start     = '0;
    in_en     = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_delay0();
    test_delay2();
    test_backpressure();
    test_gaps();
    test_misuse();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/output_deskew_register.md
Name: output_deskew_register

Overview:
- Per-column output collector at the bottom edge of the systolic array. It is the counterpart to the per-row input skew shifters.
- During the array drain phase, column c emits its ARRAYWIDTH results skewed by c cycles. This block discards the leading skew cycles and captures exactly ARRAYWIDTH results in order.
- It then replays the captured results, aligned, to the result writer over a valid/ready handshake.
- One instance per column, with DELAY_NUM = column index.

Parameters:
- DATASIZE, default `DATASIZE (16): element width in bits.
- ARRAYWIDTH, default `ARRAYWIDTH (4): results per column; depth of the internal buffer.
- DELAY_NUM, default 0: number of leading in_en cycles to discard. Legal range 0..ARRAYWIDTH-1.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse that arms a new collection. Honoured only in IDLE.
- in_en, input, 1: drain-phase strobe; in is meaningful when high.
- in, input, DATASIZE: result value from the column's bottom PE.
- out_valid, output, 1: out holds a valid result.
- out_ready, input, 1: downstream accepts out this cycle.
- out, output, DATASIZE: aligned result; 0 whenever out_valid=0.
- out_last, output, 1: high with out_valid on the final (ARRAYWIDTH-th) result.
- busy, output, 1: high in any state other than IDLE.
- overrun, output, 1: sticky error flag; cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1):
  - state=IDLE; skip_cnt, wr_ptr, rd_ptr = 0; buffer entries = 0.
  - out_valid=0, out=0, out_last=0, busy=0, overrun=0.
  - rst has priority over every other input, including mid-capture and mid-drain; a partial collection is abandoned.
- State machine:
  - IDLE, start=1:
    - DELAY_NUM>0: go to SKIP, skip_cnt=DELAY_NUM.
    - DELAY_NUM=0: go directly to CAPTURE.
    - in_en in IDLE is ignored; no flag.
  - SKIP:
    - Each cycle with in_en=1: discard in, decrement skip_cnt.
    - The in_en cycle that takes skip_cnt 1->0 moves to CAPTURE; that cycle's data is still discarded.
    - in_en=0 cycles stall; skip_cnt holds.
  - CAPTURE:
    - Each cycle with in_en=1: buf[wr_ptr]<=in, wr_ptr++.
    - The capture with wr_ptr==ARRAYWIDTH-1 moves to DRAIN, with wr_ptr<=0 and rd_ptr<=0.
    - in_en=0 stalls.
  - DRAIN:
    - out_valid=1 and out=buf[rd_ptr], combinational from registers.
    - out_last=(rd_ptr==ARRAYWIDTH-1).
    - On out_valid&&out_ready: rd_ptr++.
    - On the handshake with out_last=1: go to IDLE and clear rd_ptr. out_valid is 0 in the following cycle.
    - out_ready=0 holds out stable indefinitely.
- Latency:
  - First out_valid appears the cycle after the final capture.
  - With out_ready tied high, ARRAYWIDTH consecutive output beats.
- Boundary conditions:
  - start while busy=1: ignored; state and pointers unchanged.
  - in_en=1 while in DRAIN: data dropped, overrun<=1, drain continues unaffected.
  - start and last handshake in the same cycle: start is ignored, because state is still DRAIN.
  - Pointers are clog2(ARRAYWIDTH) wide, minimum 1 bit. Wrap-around is never reached because of the explicit compares.
  - No arithmetic is performed on data; values pass bit-exact.

Test Plan (ARRAYWIDTH=4, DATASIZE=16):
1. DELAY_NUM=0: start, then in_en high 4 cycles with in=0x11,0x22,0x33,0x44, out_ready=1 -> next cycle out=0x11..0x44 on 4 consecutive beats, out_last only on 0x44, busy falls after the 0x44 beat.
2. DELAY_NUM=2: start, then in_en high 6 cycles with in=0xAA,0xBB,0x01,0x02,0x03,0x04 -> 0xAA and 0xBB discarded; output 0x01,0x02,0x03,0x04.
3. Backpressure, DELAY_NUM=1: out_ready toggles 0,1,0,0,1,… -> each value is held while ready=0, no duplication or loss; out=0 after completion.
4. Gaps: in_en pattern 1,0,1,0,0,1,1 with DELAY_NUM=1 -> skip_cnt and wr_ptr hold during gaps; exactly the 2nd, 3rd and 4th strobed values plus the next strobed value are captured.
5. Misuse: start pulse during CAPTURE -> ignored. in_en=1 during DRAIN -> overrun=1 stays high, output sequence unchanged.
6. rst asserted mid-DRAIN after 2 beats -> next cycle out_valid=0, out=0, busy=0, overrun=0. A fresh start with DELAY_NUM=0 and 4 new values outputs only the new values.
